// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver (8E1 when UART_RX_PARITY_EN is defined) with mid-bit sampling and frame/overrun/parity flags.
// Latency: rx_valid rises 1 clk after the stop-bit sample, about 9.5 bit times after the start edge plus SYNC_STAGES clocks.
// Backpressure: the line is never stalled; a byte that completes while rx_valid is held without rx_ready is dropped with overrun_err.
module uart_rx #(
  parameter int CLK_FREQUENCY = 50000000,
  parameter int BAUD_RATE     = 115200,
  parameter int SYNC_STAGES   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun_err,
  output logic       parity_err
);

  localparam int BIT_DIV  = (CLK_FREQUENCY + BAUD_RATE / 2) / BAUD_RATE;
  localparam int HALF_DIV = BIT_DIV / 2;
  localparam int CNT_W    = $clog2(BIT_DIV);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_DIV - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic             rxd_s;
  logic             rxd_prev;
  logic             stop_sample;
  logic             par_bad;
  logic             frame_hit;
  logic             parity_hit;
  logic             byte_good;
  logic             overrun_hit;
  logic             load;

  // Synchroniser presets to the idle level so reset never fakes a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= '1;
      rxd_prev <= 1'b1;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], uart_rxd};
      rxd_prev <= rxd_s;
    end
  end

  assign rxd_s = sync_q[SYNC_STAGES-1];

`ifdef UART_RX_PARITY_EN
  logic par_q, par_d;
  always_ff @(posedge clk) begin
    if (rst) par_q <= 1'b0;
    else     par_q <= par_d;
  end
  // Even parity: data plus parity bit must carry an even number of ones.
  assign par_bad = ^{par_q, shift_q};
`else
  assign par_bad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    bit_d       = bit_q;
    shift_d     = shift_q;
    stop_sample = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d       = par_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rxd_prev && !rxd_s) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rxd_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rxd_s, shift_q[7:1]};
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          par_d   = rxd_s;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d       = '0;
          stop_sample = 1'b1;
          state_d     = rxd_s ? IDLE : BREAK;
        end
      end
      BREAK: begin
        // Hold here until the line returns high so a long break reports once.
        cnt_d = '0;
        if (rxd_s) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign frame_hit   = stop_sample && !rxd_s;
  assign parity_hit  = stop_sample && rxd_s && par_bad;
  assign byte_good   = stop_sample && rxd_s && !par_bad;
  assign overrun_hit = byte_good && rx_valid && !rx_ready;
  assign load        = byte_good && (!rx_valid || rx_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data     <= 8'h00;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      frame_err   <= frame_hit;
      overrun_err <= overrun_hit;
      if (load) begin
        rx_data  <= shift_q;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) parity_err <= 1'b0;
    else     parity_err <= parity_hit;
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frames, expected events queued by stimulus and consumed by a monitor.
module tb_uart_rx;

  localparam int BIT = 434;

  typedef struct {
    int         kind;   // 0 byte accepted, 1 frame_err, 2 overrun_err, 3 parity_err
    logic [7:0] dat;
  } ev_t;

  logic       clk_50mhz;
  logic       rst;
  logic       uart_rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun_err;
  logic       parity_err;

  int  checks = 0;
  int  errors = 0;
  ev_t exp_q[$];

  uart_rx dut (
    .clk         (clk_50mhz),
    .rst         (rst),
    .uart_rxd    (uart_rxd),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .parity_err  (parity_err)
  );

  initial clk_50mhz = 1'b0;
  always #10 clk_50mhz = ~clk_50mhz;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic push_ev(input int kind, input logic [7:0] dat);
    ev_t e;
    e.kind = kind;
    e.dat  = dat;
    exp_q.push_back(e);
  endtask

  task automatic got(input int kind, input logic [7:0] dat);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind %0d data %h expected none", kind, dat);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || (kind == 0 && e.dat !== dat)) begin
        errors++;
        $display("FAIL event: got kind %0d data %h expected kind %0d data %h", kind, dat, e.kind, e.dat);
      end
    end
  endtask

  // Monitor samples on the falling edge, away from the DUT's active edge.
  always @(negedge clk_50mhz) begin
    if (!rst) begin
      if (frame_err)           got(1, 8'h00);
      if (overrun_err)         got(2, 8'h00);
      if (parity_err)          got(3, 8'h00);
      if (rx_valid && rx_ready) got(0, rx_data);
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk_50mhz);
  endtask

  task automatic line_bit(input logic v);
    uart_rxd = v;
    wait_clks(BIT);
  endtask

  // abort_bit >= 0 pulses rst in the middle of that data bit and idles the line.
  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop, input int abort_bit);
    line_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == abort_bit) begin
        uart_rxd = b[i];
        wait_clks(BIT / 2);
        rst = 1'b1;
        wait_clks(1);
        rst      = 1'b0;
        uart_rxd = 1'b1;
        wait_clks(2 * BIT);
        return;
      end
      line_bit(b[i]);
    end
`ifdef UART_RX_PARITY_EN
    line_bit(par);
`else
    if (par) wait_clks(0);
`endif
    line_bit(stop);
  endtask

  task automatic send_ok(input logic [7:0] b);
    send_frame(b, ^b, 1'b1, -1);
  endtask

  initial begin
    rst      = 1'b1;
    uart_rxd = 1'b1;
    rx_ready = 1'b1;
    wait_clks(5);
    chk("reset_rx_valid", 32'(rx_valid), 32'd0);
    chk("reset_rx_data", 32'(rx_data), 32'h00);
    chk("reset_errs", {29'd0, frame_err, overrun_err, parity_err}, 32'd0);
    rst = 1'b0;
    wait_clks(2 * BIT);

    // Single byte with consumer ready: one-cycle rx_valid pulse.
    push_ev(0, 8'hA5);
    send_ok(8'hA5);
    wait_clks(5);
    chk("a5_valid_pulse_done", 32'(rx_valid), 32'd0);
    wait_clks(BIT);

    // Back-to-back with consumer stalled: second byte overruns.
    rx_ready = 1'b0;
    push_ev(2, 8'h00);
    push_ev(0, 8'h00);
    send_ok(8'h00);
    chk("hold_valid", 32'(rx_valid), 32'd1);
    chk("hold_data", 32'(rx_data), 32'h00);
    send_ok(8'hFF);
    wait_clks(5);
    chk("overrun_keep_data", 32'(rx_data), 32'h00);
    chk("overrun_keep_valid", 32'(rx_valid), 32'd1);
    rx_ready = 1'b1;
    wait_clks(5);
    chk("drain_valid", 32'(rx_valid), 32'd0);
    wait_clks(BIT);

    // Short low glitch on an idle line produces nothing.
    uart_rxd = 1'b0;
    wait_clks(100);
    uart_rxd = 1'b1;
    wait_clks(2 * BIT);
    chk("glitch_no_valid", 32'(rx_valid), 32'd0);

    // Stop bit low followed by a long break: exactly one frame_err.
    push_ev(1, 8'h00);
    send_frame(8'h3C, ^8'h3C, 1'b0, -1);
    uart_rxd = 1'b0;
    wait_clks(20 * BIT);
    chk("break_no_valid", 32'(rx_valid), 32'd0);
    uart_rxd = 1'b1;
    wait_clks(2 * BIT);
    push_ev(0, 8'h3C);
    send_ok(8'h3C);
    wait_clks(BIT);

    // Reset during bit 4 loses the partial byte.
    send_frame(8'h81, ^8'h81, 1'b1, 4);
    chk("rst_mid_no_valid", 32'(rx_valid), 32'd0);
    chk("rst_mid_data", 32'(rx_data), 32'h00);
    push_ev(0, 8'h55);
    send_ok(8'h55);
    wait_clks(BIT);

`ifdef UART_RX_PARITY_EN
    push_ev(3, 8'h00);
    send_frame(8'h07, 1'b0, 1'b1, -1);
    wait_clks(5);
    chk("parity_bad_no_valid", 32'(rx_valid), 32'd0);
    wait_clks(BIT);
    push_ev(0, 8'h07);
    send_frame(8'h07, 1'b1, 1'b1, -1);
    wait_clks(BIT);
`endif

    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) wait_clks(1);
    chk("events_outstanding", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
